// File: rtl/ex_stage.sv
// Execute stage: logic/shift/move datapath with a combinational EX-bypass result,
// the EX/MEM pipeline register and the architectural HI/LO pair.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [4:0]  mem_wd_o,
  output logic        mem_wreg_o,
  output logic [31:0] mem_wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // Operation codes and result classes shared with the decode stage.
  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_MOVZ_OP = 8'b0000_1010;
  localparam logic [7:0] EXE_MOVN_OP = 8'b0000_1011;
  localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP = 8'b0001_0011;

  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  logic [31:0] logic_res;
  logic [31:0] shift_res;
  logic [31:0] move_res;
  logic [4:0]  sa;
  logic [31:0] srl_val;
  logic [31:0] sign_fill;

  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [4:0]  mem_wd_reg, mem_wd_next;
  logic        mem_wreg_reg, mem_wreg_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;

  always_comb begin
    logic_res = '0;
    case (aluop_i)
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = '0;
    endcase
  end

  // SRA is the logical shift with the vacated top bits forced to reg2[31].
  assign sa        = reg1_i[4:0];
  assign srl_val   = reg2_i >> sa;
  assign sign_fill = reg2_i[31] ? ~(ALL_ONES >> sa) : '0;

  always_comb begin
    shift_res = '0;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << sa;
      EXE_SRL_OP: shift_res = srl_val;
      EXE_SRA_OP: shift_res = srl_val | sign_fill;
      default:    shift_res = '0;
    endcase
  end

  // MFHI/MFLO read the registers directly: an MTHI/MTLO one cycle earlier has
  // already landed, so no forwarding path is needed.
  always_comb begin
    move_res = '0;
    case (aluop_i)
      EXE_MFHI_OP: move_res = hi_reg;
      EXE_MFLO_OP: move_res = lo_reg;
      EXE_MOVN_OP: move_res = reg1_i;
      EXE_MOVZ_OP: move_res = reg1_i;
      default:     move_res = '0;
    endcase
  end

  always_comb begin
    wdata_o = '0;
    case (alusel_i)
      EXE_RES_LOGIC: wdata_o = logic_res;
      EXE_RES_SHIFT: wdata_o = shift_res;
      EXE_RES_MOVE:  wdata_o = move_res;
      default:       wdata_o = '0;
    endcase
  end

  assign wd_o   = wd_i;
  assign wreg_o = wreg_i;

  always_comb begin
    hi_next = hi_reg;
    lo_next = lo_reg;
    if (!stall) begin
      if (aluop_i == EXE_MTHI_OP) hi_next = reg1_i;
      if (aluop_i == EXE_MTLO_OP) lo_next = reg1_i;
    end
  end

  // A stalled EX hands a bubble to MEM rather than repeating the instruction.
  always_comb begin
    mem_wd_next    = wd_o;
    mem_wreg_next  = wreg_o;
    mem_wdata_next = wdata_o;
    if (stall) begin
      mem_wd_next    = '0;
      mem_wreg_next  = 1'b0;
      mem_wdata_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg        <= '0;
      lo_reg        <= '0;
      mem_wd_reg    <= '0;
      mem_wreg_reg  <= 1'b0;
      mem_wdata_reg <= '0;
    end else begin
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
      mem_wd_reg    <= mem_wd_next;
      mem_wreg_reg  <= mem_wreg_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  assign mem_wd_o    = mem_wd_reg;
  assign mem_wreg_o  = mem_wreg_reg;
  assign mem_wdata_o = mem_wdata_reg;
  assign hi_o        = hi_reg;
  assign lo_o        = lo_reg;

endmodule
